syscall_unit: RTL and testbench

Service engine that executes the SYSCALL instructions flagged by the control unit's syscall decode output.
- Captures $v0 (service code) and $a0 (argument) from the register file.
- Holds the datapath with stall while it works.
- Streams ASCII bytes on a valid/ready TX port.
- Reads strings from data memory.
- Latches a sticky halt on exit.
- Sits beside the single-cycle datapath, between the register file, the data memory read port and the console/UART.

---
 rtl/syscall_pkg.sv | 42 ++++
 rtl/syscall_unit_hex_ascii.sv | 14 +
 rtl/syscall_unit.sv | 187 ++++++++++++++++++
 tb/tb_syscall_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared types and constants for the SYSCALL service engine.
// SYSCALL_READ_INT_EN adds the read_int service (code 5) and its RDINT state.
package syscall_pkg;

  localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [31:0] SVC_READ_INT   = 32'd5;
  localparam logic [31:0] SVC_EXIT       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAR,
    S_HEX,
    S_STR,
`ifdef SYSCALL_READ_INT_EN
    S_RDINT,
`endif
    S_DONE,
    S_HALT
  } state_e;

  // Service code to first working state; S_IDLE marks an unsupported code.
  function automatic state_e svc_target(input logic [31:0] svc);
    state_e nxt;
    case (svc)
      SVC_PRINT_CHAR: nxt = S_CHAR;
      SVC_PRINT_INT:  nxt = S_HEX;
      SVC_PRINT_STR:  nxt = S_STR;
`ifdef SYSCALL_READ_INT_EN
      SVC_READ_INT:   nxt = S_RDINT;
`endif
      SVC_EXIT:       nxt = S_HALT;
      default:        nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/syscall_unit_hex_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit.
module hex_ascii
  import syscall_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nib_i < 4'd10) ascii_o = ASCII_0 + {4'b0000, nib_i};
    else               ascii_o = ASCII_A + ({4'b0000, nib_i} - 8'd10);
  end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service engine: console output, string fetch, exit halt and optional read_int.
// Define SYSCALL_READ_INT_EN to enable service 5 (read_int); otherwise it is rejected.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int MAX_STR = 256,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          syscall,
  input  logic [DW-1:0] v0,
  input  logic [DW-1:0] a0,
  output logic          stall,
  output logic          halt,
  output logic          bad_svc,
  output logic [DW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_rdata,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [DW-1:0] rx_data,
  output logic          wb_en,
  output logic [DW-1:0] wb_data
);

  localparam int CW = $clog2(MAX_STR + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] arg_q, arg_d;
  logic [DW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nib_q, nib_d;

  logic          tx_valid_c, rx_ready_c;
  logic [3:0]    hex_nib;
  logic [7:0]    hex_char;
  logic [7:0]    str_byte;
  state_e        target;

  assign hex_nib  = arg_q[{nib_q, 2'b00} +: 4];
  assign str_byte = dmem_rdata[{ptr_q[1:0], 3'b000} +: 8];
  assign target   = svc_target(v0);

  hex_ascii u_hex_ascii (
    .nib_i   (hex_nib),
    .ascii_o (hex_char)
  );

`ifdef SYSCALL_READ_INT_EN
  logic [DW-1:0] rd_q, rd_d;
  logic          rd_pend_q, rd_pend_d;
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path
    // through the case statement can leave a latch behind.
    state_d    = state_q;
    arg_d      = arg_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    nib_d      = nib_q;
    stall      = 1'b0;
    halt       = 1'b0;
    bad_svc    = 1'b0;
    dmem_addr  = '0;
    tx_valid_c = 1'b0;
    tx_data    = '0;
    rx_ready_c = 1'b0;
`ifdef SYSCALL_READ_INT_EN
    rd_d       = rd_q;
    rd_pend_d  = rd_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (syscall) begin
          if (target != S_IDLE) begin
            stall   = 1'b1;
            arg_d   = a0;
            ptr_d   = a0;
            cnt_d   = '0;
            nib_d   = 3'd7;
            state_d = target;
          end else begin
            bad_svc = 1'b1;
          end
        end
      end
      S_CHAR: begin
        stall      = 1'b1;
        tx_valid_c = 1'b1;
        tx_data    = arg_q[7:0];
        if (tx_ready) state_d = S_DONE;
      end
      S_HEX: begin
        stall      = 1'b1;
        tx_valid_c = 1'b1;
        tx_data    = hex_char;
        if (tx_ready) begin
          if (nib_q == 3'd0) state_d = S_DONE;
          else               nib_d   = nib_q - 3'd1;
        end
      end
      S_STR: begin
        stall     = 1'b1;
        dmem_addr = {ptr_q[DW-1:2], 2'b00};
        // The terminator or the length cap ends the string without a byte on TX.
        if (str_byte == 8'h00 || cnt_q == CW'(MAX_STR)) begin
          state_d = S_DONE;
        end else begin
          tx_valid_c = 1'b1;
          tx_data    = str_byte;
          if (tx_ready) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SYSCALL_READ_INT_EN
      S_RDINT: begin
        stall      = 1'b1;
        rx_ready_c = 1'b1;
        if (rx_valid) begin
          rd_d      = rx_data;
          rd_pend_d = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // syscall is deliberately ignored: the retiring instruction must not re-fire.
        state_d = S_IDLE;
`ifdef SYSCALL_READ_INT_EN
        rd_pend_d = 1'b0;
`endif
      end
      S_HALT: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshakes are masked during reset so an aborted transfer is never accepted.
  assign tx_valid = tx_valid_c & ~reset;
  assign rx_ready = rx_ready_c & ~reset;

`ifdef SYSCALL_READ_INT_EN
  assign wb_en   = (state_q == S_DONE) && rd_pend_q;
  assign wb_data = wb_en ? rd_q : '0;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_valid, rx_data};
  assign wb_en     = 1'b0;
  assign wb_data   = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      arg_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
`ifdef SYSCALL_READ_INT_EN
      rd_q      <= '0;
      rd_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
`ifdef SYSCALL_READ_INT_EN
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table plus multi-cycle corner sequences.
// Honours SYSCALL_READ_INT_EN the same way as the design.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset, syscall;
  logic [31:0] v0, a0;
  logic        stall, halt, bad_svc;
  logic [31:0] dmem_addr, dmem_rdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic        wb_en;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  syscall_unit dut (
    .clk(clk), .reset(reset), .syscall(syscall), .v0(v0), .a0(a0),
    .stall(stall), .halt(halt), .bad_svc(bad_svc),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .wb_en(wb_en), .wb_data(wb_data)
  );

  // Byte-addressed data memory model, little-endian word reads.
  logic [7:0] mem [0:1023];
  logic [9:0] ai;
  assign ai = {dmem_addr[9:2], 2'b00};
  assign dmem_rdata = {mem[ai + 10'd3], mem[ai + 10'd2], mem[ai + 10'd1], mem[ai]};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          nb;
    logic [63:0] bytes;
    bit          bad;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  got[$];
  logic [31:0] addrs[$];
  int          retires, stable_err;
  bit          saw_bad, done;

  function automatic logic [63:0] pack_got();
    logic [63:0] p = '0;
    foreach (got[i]) p = {p[55:0], got[i]};
    return p;
  endfunction

  // Issue one SYSCALL and play the datapath: syscall stays high until the cycle it retires.
  task automatic run_svc(input logic [31:0] v, input logic [31:0] a, input bit toggle,
                         input int max_cyc);
    bit pend = 1'b0;
    logic [7:0] held = '0;
    bit retire;
    got.delete(); addrs.delete();
    retires = 0; stable_err = 0; saw_bad = 1'b0; done = 1'b0;
    v0 = v; a0 = a; syscall = 1'b1; tx_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (pend && (!tx_valid || tx_data !== held)) stable_err++;
      pend = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (dmem_addr != 32'd0 && (addrs.size() == 0 || addrs[$] != dmem_addr))
        addrs.push_back(dmem_addr);
      if (bad_svc) saw_bad = 1'b1;
      retire = syscall && !stall;
      if (retire) retires++;
      @(posedge clk); #1;
      if (retire) begin
        syscall = 1'b0;
        done = 1'b1;
        break;
      end
      if (toggle) tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, {60'd0, stall, tx_valid, bad_svc, halt}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, nb, wbs;
    logic [31:0] wbv;
    bit rdy_seen;

    foreach (mem[i]) mem[i] = 8'h00;
    mem[10'h103] = 8'h48; mem[10'h104] = 8'h69; mem[10'h105] = 8'h00;
    for (int i = 0; i < 300; i++) mem[10'h200 + i[9:0]] = 8'h61;
    for (int i = 0; i < 6; i++) mem[10'h380 + i[9:0]] = 8'h41 + i[7:0];

    vecs.push_back('{32'd11, 32'h0000_0041, 1, 64'h41, 1'b0});
    vecs.push_back('{32'd11, 32'h1234_567A, 1, 64'h7A, 1'b0});
    vecs.push_back('{32'd1,  32'hDEAD_BEEF, 8, 64'h4445414442454546, 1'b0});
    vecs.push_back('{32'd1,  32'h0123_4567, 8, 64'h3031323334353637, 1'b0});
    vecs.push_back('{32'd1,  32'h89AB_CDEF, 8, 64'h3839414243444546, 1'b0});
    vecs.push_back('{32'd1,  32'h0000_0000, 8, 64'h3030303030303030, 1'b0});
    vecs.push_back('{32'd7,  32'h0000_0041, 0, 64'h0, 1'b1});
    vecs.push_back('{32'd0,  32'h0000_0041, 0, 64'h0, 1'b1});
`ifndef SYSCALL_READ_INT_EN
    vecs.push_back('{32'd5,  32'h0000_0041, 0, 64'h0, 1'b1});
`endif

    reset = 1'b1; syscall = 1'b0; v0 = '0; a0 = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {stall, halt, bad_svc, tx_valid, rx_ready, wb_en, tx_data},
          64'd0);
    check("reset_addr_wb", {dmem_addr, wb_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      run_svc(vecs[k].v0, vecs[k].a0, 1'b0, 40);
      check($sformatf("vec%0d_done", k), {63'd0, done}, 64'd1);
      check($sformatf("vec%0d_nbytes", k), got.size(), vecs[k].nb);
      check($sformatf("vec%0d_bytes", k), pack_got(), vecs[k].bytes);
      check($sformatf("vec%0d_bad", k), {63'd0, saw_bad}, {63'd0, vecs[k].bad});
      check($sformatf("vec%0d_retires", k), retires, 1);
      idle_check($sformatf("vec%0d_idle_after", k));
      @(posedge clk); #1;
    end

    // print_int against a sink that stalls every other cycle.
    run_svc(32'd1, 32'hDEAD_BEEF, 1'b1, 100);
    check("hex_toggle_done", {63'd0, done}, 64'd1);
    check("hex_toggle_bytes", pack_got(), 64'h4445414442454546);
    check("hex_toggle_stable", stable_err, 0);

    // print_string starting mid-word: two words fetched, NUL not emitted.
    run_svc(32'd4, 32'h0000_0103, 1'b0, 40);
    check("str_done", {63'd0, done}, 64'd1);
    check("str_bytes", pack_got(), 64'h4869);
    check("str_nbytes", got.size(), 2);
    check("str_addr_count", addrs.size(), 2);
    if (addrs.size() == 2) check("str_addrs", {addrs[0], addrs[1]}, {32'h100, 32'h104});

    // Unterminated string stops at the length cap.
    run_svc(32'd4, 32'h0000_0200, 1'b0, 400);
    check("maxstr_done", {63'd0, done}, 64'd1);
    check("maxstr_nbytes", got.size(), 256);

    // Reset in the middle of a string.
    got.delete();
    v0 = 32'd4; a0 = 32'h380; syscall = 1'b1; tx_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (got.size() < 2) begin @(posedge clk); #1; end
    end
    check("rst_mid_first_bytes", pack_got(), 64'h4142);
    @(posedge clk); #1;
    reset = 1'b1; syscall = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_valid", {63'd0, tx_valid}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid) nb++;
    end
    check("rst_mid_no_more_tx", nb, 0);
    check("rst_mid_outputs", {stall, halt, bad_svc, rx_ready, wb_en, tx_data, dmem_addr},
          64'd0);
    @(posedge clk); #1;

`ifdef SYSCALL_READ_INT_EN
    // read_int with the integer arriving after five cycles.
    v0 = 32'd5; a0 = '0; syscall = 1'b1; rx_data = 32'h1234;
    wbs = 0; wbv = '0; rdy_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rx_valid = (c >= 5);
      @(negedge clk);
      if (rx_ready) rdy_seen = 1'b1;
      if (wb_en) begin wbs++; wbv = wb_data; end
      if (syscall && !stall) begin
        @(posedge clk); #1;
        syscall = 1'b0; rx_valid = 1'b0; done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    check("rdint_done", {63'd0, done}, 64'd1);
    check("rdint_rx_ready", {63'd0, rdy_seen}, 64'd1);
    check("rdint_wb_pulses", wbs, 1);
    check("rdint_wb_data", wbv, 32'h1234);
    idle_check("rdint_idle_after");
    @(posedge clk); #1;
`endif

    // exit: halt and stall persist until reset.
    v0 = 32'd10; a0 = '0; syscall = 1'b1;
    @(posedge clk); #1;
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!(halt && stall)) errs++;
      @(posedge clk); #1;
    end
    check("halt_persist", errs, 0);
    reset = 1'b1; syscall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_check("halt_cleared");
    @(posedge clk); #1;

    // Unit still operational after the halt/reset.
    run_svc(32'd11, 32'h0000_007E, 1'b0, 40);
    check("post_halt_char", pack_got(), 64'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
